// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: opcodes, load/store funct3 codes, data-memory FSM
// encoding and the load-data extension helper.
package riscv_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    DM_IDLE   = 2'd0,
    DM_ACCESS = 2'd1,
    DM_RESP   = 2'd2
  } dmem_state_t;

  // Picks the addressed byte/half lane out of a RAM word and extends it.
  function automatic logic [31:0] load_extend(input logic [2:0] f3,
                                              input logic [1:0] off,
                                              input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      F3_B:    load_extend = {{24{b[7]}}, b};
      F3_BU:   load_extend = {24'b0, b};
      F3_H:    load_extend = {{16{h[15]}}, h};
      F3_HU:   load_extend = {16'b0, h};
      default: load_extend = word;
    endcase
  endfunction

endpackage

// File: rtl/riscv_dmem_ram.sv
// Word-organised data RAM with per-byte write enables and a registered read port.
module riscv_dmem_ram #(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [2**AW];

  // Contents and read register are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < 4; i++) begin
          if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/riscv_dmem_ctrl.sv
// Data-memory responder: checks load/store requests, drives the RAM for one
// ACCESS cycle and returns extended load data with an error flag.
module riscv_dmem_ctrl
  import riscv_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output dmem_state_t dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are
  // both high; valid-side payload is held stable until that edge.

  dmem_state_t       state;
  logic              wr_q;
  logic [2:0]        f3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic              req_err;
  logic [3:0]        ram_be;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata;

  assign req_ready = (state == DM_IDLE);
  assign dbg_state = state;

  always_comb begin
    req_err = 1'b0;
    case (req_funct3)
      F3_B:    req_err = 1'b0;
      F3_H:    req_err = req_addr[0];
      F3_W:    req_err = |req_addr[1:0];
      F3_BU:   req_err = req_write;
      F3_HU:   req_err = req_write | req_addr[0];
      default: req_err = 1'b1;
    endcase
    if (|req_addr[31:ADDR_W]) req_err = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= DM_IDLE;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      wr_q      <= 1'b0;
      f3_q      <= 3'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
    end else begin
      case (state)
        DM_IDLE: begin
          if (req_valid) begin
            wr_q    <= req_write;
            f3_q    <= req_funct3;
            addr_q  <= req_addr[ADDR_W-1:0];
            wdata_q <= req_wdata;
            if (req_err) begin
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              state     <= DM_RESP;
            end else begin
              state <= DM_ACCESS;
            end
          end
        end
        DM_ACCESS: begin
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b0;
          state     <= DM_RESP;
        end
        DM_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            state     <= DM_IDLE;
          end
        end
        default: state <= DM_IDLE;
      endcase
    end
  end

  // Narrow stores replicate their data across lanes; byte enables pick the lane.
  always_comb begin
    ram_be    = 4'b1111;
    ram_wdata = wdata_q;
    case (f3_q[1:0])
      2'b00: begin
        ram_be    = 4'b0001 << addr_q[1:0];
        ram_wdata = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        ram_be    = 4'b0011 << addr_q[1:0];
        ram_wdata = {2{wdata_q[15:0]}};
      end
      default: ;
    endcase
  end

  riscv_dmem_ram #(.AW(ADDR_W-2)) u_ram (
    .clk   (clk),
    .en    (state == DM_ACCESS),
    .we    (wr_q),
    .be    (ram_be),
    .addr  (addr_q[ADDR_W-1:2]),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // The read register is unreset and holds through RESP, so it is gated here.
  assign rsp_rdata = (state == DM_RESP && !wr_q && !rsp_err)
                   ? load_extend(f3_q, addr_q[1:0], ram_rdata) : 32'h0;

endmodule

// File: tb/tb_riscv_dmem_ctrl.sv
// Directed bench for riscv_dmem_ctrl: stores, loads, error requests, response
// back-pressure and reset during ACCESS.
module tb_riscv_dmem_ctrl;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [2:0]  req_funct3 = 3'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  dmem_state_t dbg_state;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  riscv_dmem_ctrl #(.ADDR_W(12)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .dbg_state  (dbg_state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Called at posedge+1 with the DUT idle; returns at posedge+1 after the handshake.
  task automatic xact(input string tag, input logic w, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] wd,
                      input logic [31:0] exp_d, input logic exp_e);
    int cyc;
    chk({tag, ".req_ready"}, {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; req_write = w; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    cyc = 1;
    while (!rsp_valid && cyc < 8) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk({tag, ".latency"}, cyc, exp_e ? 32'd1 : 32'd2);
    chk({tag, ".rdata"}, rsp_rdata, exp_d);
    chk({tag, ".err"}, {31'b0, rsp_err}, {31'b0, exp_e});
    chk({tag, ".busy"}, {31'b0, req_ready}, 32'd0);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk({tag, ".done"}, {31'b0, rsp_valid}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Clock/reset
    repeat (2) @(posedge clk);
    #1;
    chk("rst.req_ready", {31'b0, req_ready}, 32'd1);
    chk("rst.rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst.rsp_rdata", rsp_rdata, 32'h0);
    chk("rst.rsp_err", {31'b0, rsp_err}, 32'd0);
    chk("rst.state", {30'b0, dbg_state}, {30'b0, DM_IDLE});
    rst = 1'b0;
    @(posedge clk); #1;

    // Word store/load and sub-word lanes
    xact("sw_010",  1'b1, F3_W,  32'h010, 32'hDEADBEEF, 32'h0,        1'b0);
    xact("lw_010",  1'b0, F3_W,  32'h010, 32'h0,        32'hDEADBEEF, 1'b0);
    xact("sb_013",  1'b1, F3_B,  32'h013, 32'h0000007F, 32'h0,        1'b0);
    xact("lb_013",  1'b0, F3_B,  32'h013, 32'h0,        32'h0000007F, 1'b0);
    xact("lw_010b", 1'b0, F3_W,  32'h010, 32'h0,        32'h7FADBEEF, 1'b0);
    xact("lbu_012", 1'b0, F3_BU, 32'h012, 32'h0,        32'h000000AD, 1'b0);
    xact("lb_012",  1'b0, F3_B,  32'h012, 32'h0,        32'hFFFFFFAD, 1'b0);
    xact("sw_020",  1'b1, F3_W,  32'h020, 32'h11223344, 32'h0,        1'b0);
    xact("sh_022",  1'b1, F3_H,  32'h022, 32'h00008001, 32'h0,        1'b0);
    xact("lh_022",  1'b0, F3_H,  32'h022, 32'h0,        32'hFFFF8001, 1'b0);
    xact("lhu_022", 1'b0, F3_HU, 32'h022, 32'h0,        32'h00008001, 1'b0);
    xact("lw_020",  1'b0, F3_W,  32'h020, 32'h0,        32'h80013344, 1'b0);
    xact("sw_000",  1'b1, F3_W,  32'h000, 32'hA5A5A5A5, 32'h0,        1'b0);
    xact("lh_000",  1'b0, F3_H,  32'h000, 32'h0,        32'hFFFFA5A5, 1'b0);

    // Error requests: no RAM access, one-cycle response
    xact("e_lw_011",  1'b0, F3_W,   32'h011,       32'h0,        32'h0, 1'b1);
    xact("e_sh_003",  1'b1, F3_H,   32'h003,       32'h0000FFFF, 32'h0, 1'b1);
    xact("e_sbu",     1'b1, F3_BU,  32'h010,       32'hFFFFFFFF, 32'h0, 1'b1);
    xact("e_f3_011",  1'b0, 3'b011, 32'h010,       32'h0,        32'h0, 1'b1);
    xact("e_range",   1'b0, F3_W,   32'h00010000,  32'h0,        32'h0, 1'b1);
    xact("e_sw_1010", 1'b1, F3_W,   32'h00001010,  32'hFFFFFFFF, 32'h0, 1'b1);
    xact("post_lw_000", 1'b0, F3_W, 32'h000, 32'h0, 32'hA5A5A5A5, 1'b0);
    xact("post_lw_010", 1'b0, F3_W, 32'h010, 32'h0, 32'h7FADBEEF, 1'b0);

    // Consumer stall with a request waiting
    req_valid = 1'b1; req_write = 1'b0; req_funct3 = F3_W; req_addr = 32'h010;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk("stall.valid0", {31'b0, rsp_valid}, 32'd1);
    req_valid = 1'b1; req_addr = 32'h020;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("stall.valid", {31'b0, rsp_valid}, 32'd1);
      chk("stall.rdata", rsp_rdata, 32'h7FADBEEF);
      chk("stall.req_ready", {31'b0, req_ready}, 32'd0);
      chk("stall.state", {30'b0, dbg_state}, {30'b0, DM_RESP});
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("stall.released", {31'b0, rsp_valid}, 32'd0);
    chk("stall.idle", {30'b0, dbg_state}, {30'b0, DM_IDLE});
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("stall.accepted", {30'b0, dbg_state}, {30'b0, DM_ACCESS});
    @(posedge clk); #1;
    chk("stall.q_valid", {31'b0, rsp_valid}, 32'd1);
    chk("stall.q_rdata", rsp_rdata, 32'h80013344);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;

    // Reset while a store sits in ACCESS
    xact("sw_040", 1'b1, F3_W, 32'h040, 32'hCAFEF00D, 32'h0, 1'b0);
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = F3_W;
    req_addr = 32'h040; req_wdata = 32'h12345678;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("rsta.state", {30'b0, dbg_state}, {30'b0, DM_ACCESS});
    rst = 1'b1;
    #1;
    chk("rsta.valid", {31'b0, rsp_valid}, 32'd0);
    chk("rsta.req_ready", {31'b0, req_ready}, 32'd1);
    chk("rsta.state_idle", {30'b0, dbg_state}, {30'b0, DM_IDLE});
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("rsta.no_rsp", {31'b0, rsp_valid}, 32'd0);
    end
    xact("rsta.lw_040", 1'b0, F3_W, 32'h040, 32'h0, 32'hCAFEF00D, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/riscv_dmem_ctrl.md
# riscv_dmem_ctrl

Data-memory responder for the single-cycle RISC-V datapath: accepts load/store requests (issued when the control decoder asserts mem_write or result_src) over a valid/ready handshake, performs byte/half/word access on an internal word-organised RAM, and returns sign- or zero-extended load data with an error flag. It sits between the core's ALU/address path and the data store, and it is the memory-side counterpart of the LOAD/STORE decode.

## Interface
- ADDR_W, 12: byte-address bits decoded; RAM holds 2**(ADDR_W-2) 32-bit words
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  block can accept request (high only in IDLE)
- req_write  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I load/store funct3
- req_addr  in  32  byte address (ALU result)
- req_wdata  in  32  store data (rs2), right-aligned
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_rdata  out  32  extended load data; 0 for stores and errors
- rsp_err  out  1  misaligned, out-of-range, or illegal funct3

## Operation
- States: IDLE, ACCESS, RESP. Reset -> IDLE; req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0. RAM contents not reset.
- IDLE: on req_valid && req_ready, capture write, funct3, addr, wdata; check request.
  - Error if: funct3 not in {000,001,010,100,101}; req_write with funct3 100/101; half with addr[0]=1; word with addr[1:0]!=0; addr[31:ADDR_W]!=0.
  - Error -> RESP with rsp_err=1, rsp_rdata=0, no RAM access. Else -> ACCESS.
- ACCESS (one cycle): word index = addr[ADDR_W-1:2].
  - Store: byte enables SB=0001<<addr[1:0], SH=0011<<addr[1:0], SW=1111; wdata lanes replicated (byte x4, half x2); only enabled bytes change. rsp_rdata=0.
  - Load: registered word read; select byte lane addr[1:0] or half lane addr[1]; LB/LH sign-extend, LBU/LHU zero-extend, LW pass-through.
  - -> RESP, rsp_err=0.
- RESP: rsp_valid=1, rsp_rdata/rsp_err stable until rsp_valid && rsp_ready; then -> IDLE and rsp_valid=0, rsp_rdata=0, rsp_err=0 at the same edge.
- Requests are not accepted in ACCESS or RESP. Consumer stalls are unbounded.

## Timing
- Accept edge E0 -> ACCESS; RAM read/write at E1 -> RESP; rsp_valid high from E1. Valid request: response 2 cycles after accept.
- Error request: rsp_valid high from E0, 1 cycle after accept.
- rsp_ready already high in RESP: response consumed at the next edge. Minimum spacing between accepts is 3 cycles for valid requests and 2 cycles for error requests.
- Load from the address written by the immediately previous store returns the new data, because the store completes at its E1 before the next accept.
- rst asserted in ACCESS before E1: store dropped (RAM unchanged), no response. Any reset clears outputs asynchronously and returns to IDLE.

## Structure
- Shared package riscv_pkg: opcode localparams (OP_LOAD, OP_STORE, …), funct3 constants F3_B/F3_H/F3_W/F3_BU/F3_HU, state encoding for this FSM.
- Sub-module riscv_dmem_ram: word array, 4-bit byte-enable write, registered read, no reset. The FSM, checking, lane steering, and extension stay in riscv_dmem_ctrl.

## Test plan
- SW 0xDEADBEEF @0x010, then LW @0x010 -> rsp_rdata=0xDEADBEEF, rsp_err=0; rsp_valid 2 cycles after each accept.
- After the above, SB 0x7F @0x013, then LB @0x013 -> 0x0000007F; LW @0x010 -> 0x7FADBEEF; LBU @0x012 -> 0x000000AD; LB @0x012 -> 0xFFFFFFAD.
- SH 0x8001 @0x022, then LH @0x022 -> 0xFFFF8001; LHU @0x022 -> 0x00008001; LW @0x020 -> upper half 0x8001.
- LW @0x011, SH @0x003, LBU with req_write=1, funct3=011, and addr 0x0001_0000 -> each gives rsp_err=1, rsp_rdata=0, rsp_valid 1 cycle after accept, and RAM is unchanged (checked by a follow-up LW).
- Hold rsp_ready=0 for 5 cycles in RESP -> outputs stable, req_ready=0; a request offered in that window is not accepted until after the response handshake.
- Assert rst during ACCESS of SW 0x12345678 @0x040 -> rsp_valid never asserts, and a later LW @0x040 returns the prior value.
